// File: rtl/cam_capture.sv
// OV7670 pixel capture: pairs RGB444 bytes from the camera bus into 12-bit
// pixels and writes them to the frame buffer at linear addresses, one per pixel.
module cam_capture #(
  parameter int FRAME_PIXELS = 307200
) (
  input  logic        i_pclk,
  input  logic        i_rstn_pclk,
  input  logic        i_cfg_done,
  input  logic        i_cam_vsync,
  input  logic        i_cam_href,
  input  logic [7:0]  i_cam_data,
  output logic        o_pix_wr_en,
  output logic [18:0] o_pix_wr_addr,
  output logic [11:0] o_pix_wr_data,
  output logic        o_frame_done,
  output logic        o_frame_ok,
  output logic        o_busy
);

  localparam logic [18:0] LP_FRAME = 19'(FRAME_PIXELS);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT_VS = 2'd1,
    S_CAPTURE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic        r_vsync;
  logic        r_vsync_d;
  logic        r_href;
  logic [7:0]  r_data;
  logic        r_phase;
  logic [3:0]  r_red;
  logic [18:0] r_cnt;
  logic        r_ovf;
  logic        r_wr_en;
  logic [18:0] r_addr;
  logic [11:0] r_wdata;
  logic        r_done;
  logic        r_ok;

  logic        w_vs_fall;
  logic        w_vs_rise;
  logic        w_pair;
  logic        w_full;
  logic        w_write;
  logic        w_drop;
  logic [18:0] w_cnt_inc;
  logic [18:0] w_cnt_after;
  logic        w_ovf_after;
  logic        w_frame_ok;

  assign w_vs_fall = r_vsync_d & ~r_vsync;
  assign w_vs_rise = ~r_vsync_d & r_vsync;

  always_comb begin
    w_pair      = (r_state == S_CAPTURE) & r_href & r_phase;
    w_full      = (r_cnt == LP_FRAME);
    w_write     = w_pair & ~w_full;
    w_drop      = w_pair & w_full;
    w_cnt_inc   = r_cnt + 19'd1;
    // A pair landing in the closing cycle still counts toward this frame.
    w_cnt_after = w_write ? w_cnt_inc : r_cnt;
    w_ovf_after = r_ovf | w_drop;
    w_frame_ok  = (w_cnt_after == LP_FRAME) & ~w_ovf_after;
  end

  always_ff @(posedge i_pclk) begin
    if (!i_rstn_pclk) r_state <= S_IDLE;
    else              r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (i_cfg_done) w_state_nxt = S_WAIT_VS;
      S_WAIT_VS: if (w_vs_fall)  w_state_nxt = S_CAPTURE;
      S_CAPTURE: if (w_vs_rise)  w_state_nxt = S_WAIT_VS;
      default:                   w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_pclk) begin
    if (!i_rstn_pclk) begin
      r_vsync   <= 1'b0;
      r_vsync_d <= 1'b0;
      r_href    <= 1'b0;
      r_data    <= 8'd0;
      r_phase   <= 1'b0;
      r_red     <= 4'd0;
      r_cnt     <= 19'd0;
      r_ovf     <= 1'b0;
      r_wr_en   <= 1'b0;
      r_addr    <= 19'd0;
      r_wdata   <= 12'd0;
      r_done    <= 1'b0;
      r_ok      <= 1'b0;
    end else begin
      r_vsync   <= i_cam_vsync;
      r_vsync_d <= r_vsync;
      r_href    <= i_cam_href;
      r_data    <= i_cam_data;
      r_wr_en   <= 1'b0;
      r_done    <= 1'b0;
      if (r_state == S_WAIT_VS && w_vs_fall) begin
        r_cnt   <= 19'd0;
        r_ovf   <= 1'b0;
        r_phase <= 1'b0;
        r_addr  <= 19'd0;
      end else if (r_state == S_CAPTURE) begin
        // HREF low discards any unpaired first byte.
        r_phase <= r_href ? ~r_phase : 1'b0;
        if (r_href && !r_phase) r_red <= r_data[3:0];
        if (w_write) begin
          r_wr_en <= 1'b1;
          r_addr  <= r_cnt;
          r_wdata <= {r_red, r_data};
          r_cnt   <= w_cnt_inc;
        end
        if (w_drop) r_ovf <= 1'b1;
        if (w_vs_rise) begin
          r_done  <= 1'b1;
          r_ok    <= w_frame_ok;
          r_phase <= 1'b0;
        end
      end else begin
        r_phase <= 1'b0;
      end
    end
  end

  assign o_pix_wr_en   = r_wr_en;
  assign o_pix_wr_addr = r_addr;
  assign o_pix_wr_data = r_wdata;
  assign o_frame_done  = r_done;
  assign o_frame_ok    = r_ok;
  assign o_busy        = (r_state == S_CAPTURE);

endmodule

// File: tb/tb_cam_capture.sv
// Directed bench for cam_capture on a reduced 8x5 frame so whole frames,
// short/long frames and the overflow boundary fit in a short run.
module tb_cam_capture;

  localparam int LP_W   = 8;
  localparam int LP_H   = 5;
  localparam int LP_PIX = LP_W * LP_H;

  logic        clk = 1'b0;
  logic        rstn;
  logic        cfg_done;
  logic        vsync;
  logic        href;
  logic [7:0]  data;
  logic        wr_en;
  logic [18:0] wr_addr;
  logic [11:0] wr_data;
  logic        frame_done;
  logic        frame_ok;
  logic        busy;

  always #5 clk = ~clk;

  cam_capture #(.FRAME_PIXELS(LP_PIX)) dut (
    .i_pclk        (clk),
    .i_rstn_pclk   (rstn),
    .i_cfg_done    (cfg_done),
    .i_cam_vsync   (vsync),
    .i_cam_href    (href),
    .i_cam_data    (data),
    .o_pix_wr_en   (wr_en),
    .o_pix_wr_addr (wr_addr),
    .o_pix_wr_data (wr_data),
    .o_frame_done  (frame_done),
    .o_frame_ok    (frame_ok),
    .o_busy        (busy)
  );

  int checks = 0;
  int errors = 0;

  int          mon_wr;
  int          mon_done;
  int          mon_bad;
  logic [18:0] mon_exp_addr;
  logic [18:0] mon_last_addr;
  logic [11:0] mon_exp_data;
  bit          mon_chk_data;
  logic        mon_prev_en = 1'b0;

  // Write-port watcher: sequential addresses, expected data, never back-to-back.
  always @(posedge clk) begin
    #1;
    if (wr_en === 1'b1) begin
      mon_wr++;
      mon_last_addr = wr_addr;
      if (wr_addr !== mon_exp_addr) mon_bad++;
      if (mon_chk_data && wr_data !== mon_exp_data) mon_bad++;
      if (mon_prev_en === 1'b1) mon_bad++;
      mon_exp_addr++;
    end
    if (frame_done === 1'b1) mon_done++;
    mon_prev_en = wr_en;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic mon_clear(input logic [11:0] ed, input bit cd);
    mon_wr        = 0;
    mon_done      = 0;
    mon_bad       = 0;
    mon_exp_addr  = 19'd0;
    mon_last_addr = 19'h7FFFF;
    mon_exp_data  = ed;
    mon_chk_data  = cd;
  endtask

  task automatic put(input logic vs, input logic hr, input logic [7:0] d);
    @(negedge clk);
    vsync = vs;
    href  = hr;
    data  = d;
  endtask

  task automatic vs_start();
    repeat (3) put(1'b1, 1'b0, 8'h00);
    repeat (5) put(1'b0, 1'b0, 8'h00);
  endtask

  task automatic vs_end();
    repeat (4) put(1'b1, 1'b0, 8'h00);
  endtask

  task automatic send_line(input int nbytes, input bit vs_last);
    for (int i = 0; i < nbytes; i++)
      put(vs_last && (i == nbytes - 1), 1'b1, (i % 2 == 0) ? 8'h0A : 8'hBC);
    repeat (3) put(vs_last, 1'b0, 8'h00);
  endtask

  task automatic frame(input int nlines, input int odd_line);
    vs_start();
    for (int l = 0; l < nlines; l++)
      send_line((l == odd_line) ? 2 * LP_W + 1 : 2 * LP_W, 1'b0);
    vs_end();
  endtask

  initial begin
    rstn = 1'b0; cfg_done = 1'b0; vsync = 1'b0; href = 1'b0; data = 8'h00;
    mon_clear(12'h000, 1'b0);
    repeat (3) @(negedge clk);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_addr",  wr_addr, 0);
    chk("rst_data",  wr_data, 0);
    chk("rst_done",  frame_done, 0);
    chk("rst_ok",    frame_ok, 0);
    chk("rst_busy",  busy, 0);
    rstn = 1'b1;

    // Start-up gating: nothing while cfg_done low, nor in the frame it rises in.
    mon_clear(12'h000, 1'b0);
    frame(LP_H, -1);
    chk("gate_off_writes", mon_wr, 0);
    chk("gate_off_done", mon_done, 0);
    mon_clear(12'h000, 1'b0);
    vs_start();
    send_line(2 * LP_W, 1'b0);
    send_line(2 * LP_W, 1'b0);
    cfg_done = 1'b1;
    for (int l = 2; l < LP_H; l++) send_line(2 * LP_W, 1'b0);
    vs_end();
    chk("gate_mid_writes", mon_wr, 0);
    chk("gate_mid_done", mon_done, 0);
    chk("gate_mid_busy", busy, 0);

    // Latency: first pixel 0x05,0x6F appears 2 edges after 0x6F is driven.
    mon_clear(12'h000, 1'b0);
    vs_start();
    chk("lat_busy", busy, 1);
    put(1'b0, 1'b1, 8'h05);
    put(1'b0, 1'b1, 8'h6F);
    @(posedge clk); #1;
    chk("lat_edge_n_en", wr_en, 0);
    put(1'b0, 1'b0, 8'h00);
    @(posedge clk); #1;
    chk("lat_edge_n1_en", wr_en, 1);
    chk("lat_addr0", wr_addr, 0);
    chk("lat_data0", wr_data, 12'h56F);
    put(1'b0, 1'b1, 8'h07);
    put(1'b0, 1'b1, 8'h8A);
    put(1'b0, 1'b1, 8'h03);
    put(1'b0, 1'b0, 8'h00);
    put(1'b0, 1'b0, 8'h00);
    chk("lat_addr1", wr_addr, 1);
    chk("lat_data1", wr_data, 12'h78A);
    chk("lat_writes", mon_wr, 2);
    vs_end();
    chk("lat_done", mon_done, 1);
    chk("lat_ok", frame_ok, 0);
    chk("lat_bad", mon_bad, 0);

    // Nominal full frame.
    mon_clear(12'hABC, 1'b1);
    frame(LP_H, -1);
    chk("nom_writes", mon_wr, LP_PIX);
    chk("nom_last_addr", mon_last_addr, LP_PIX - 1);
    chk("nom_bad", mon_bad, 0);
    chk("nom_done", mon_done, 1);
    chk("nom_ok", frame_ok, 1);
    chk("nom_busy", busy, 0);

    // Odd-length line: dangling byte dropped, alignment kept.
    mon_clear(12'hABC, 1'b1);
    frame(LP_H, 2);
    chk("odd_writes", mon_wr, LP_PIX);
    chk("odd_bad", mon_bad, 0);
    chk("odd_ok", frame_ok, 1);

    // Short frame.
    mon_clear(12'hABC, 1'b1);
    frame(LP_H - 1, -1);
    chk("short_writes", mon_wr, LP_PIX - LP_W);
    chk("short_last_addr", mon_last_addr, LP_PIX - LP_W - 1);
    chk("short_ok", frame_ok, 0);
    chk("short_bad", mon_bad, 0);

    // Long frame: writes stop at the last address, overflow clears ok.
    mon_clear(12'hABC, 1'b1);
    frame(LP_H + 1, -1);
    chk("long_writes", mon_wr, LP_PIX);
    chk("long_last_addr", mon_last_addr, LP_PIX - 1);
    chk("long_addr_hold", wr_addr, LP_PIX - 1);
    chk("long_ok", frame_ok, 0);
    chk("long_done", mon_done, 1);
    chk("long_bad", mon_bad, 0);

    // Final pixel coincides with VSYNC rise.
    mon_clear(12'hABC, 1'b1);
    vs_start();
    for (int l = 0; l < LP_H - 1; l++) send_line(2 * LP_W, 1'b0);
    send_line(2 * LP_W, 1'b1);
    vs_end();
    chk("simul_writes", mon_wr, LP_PIX);
    chk("simul_ok", frame_ok, 1);
    chk("simul_done", mon_done, 1);

    // Reset mid-capture at pixel 20.
    mon_clear(12'hABC, 1'b1);
    vs_start();
    send_line(2 * LP_W, 1'b0);
    for (int i = 0; i < 2 * LP_W + 8; i++)
      put(1'b0, 1'b1, (i % 2 == 0) ? 8'h0A : 8'hBC);
    put(1'b0, 1'b0, 8'h00);
    put(1'b0, 1'b0, 8'h00);
    chk("rstmid_pre_writes", mon_wr, 20);
    rstn = 1'b0;
    @(posedge clk); #1;
    chk("rstmid_wr_en", wr_en, 0);
    chk("rstmid_addr", wr_addr, 0);
    chk("rstmid_data", wr_data, 0);
    chk("rstmid_ok", frame_ok, 0);
    chk("rstmid_busy", busy, 0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    mon_clear(12'hABC, 1'b1);
    send_line(2 * LP_W, 1'b0);
    send_line(2 * LP_W, 1'b0);
    vs_end();
    chk("rstmid_rest_writes", mon_wr, 0);
    chk("rstmid_rest_done", mon_done, 0);
    mon_clear(12'hABC, 1'b1);
    frame(LP_H, -1);
    chk("rstmid_next_writes", mon_wr, LP_PIX);
    chk("rstmid_next_bad", mon_bad, 0);
    chk("rstmid_next_ok", frame_ok, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
